// File: rtl/uart_word_pkg.sv
// Shared encodings and byte-order helpers for the UART word bridge.
package uart_word_pkg;

  localparam logic [0:0] RX_FIRST  = 1'b0;
  localparam logic [0:0] RX_SECOND = 1'b1;

  localparam logic [1:0] TX_IDLE   = 2'd0;
  localparam logic [1:0] TX_FIRST  = 2'd1;
  localparam logic [1:0] TX_SECOND = 2'd2;

  localparam bit MSB_FIRST_DEFAULT = 1'b1;

  localparam int ERR_RX_DROP    = 0;
  localparam int ERR_RX_TIMEOUT = 1;

  function automatic logic [15:0] word_join(input logic [7:0] first_b,
                                            input logic [7:0] second_b,
                                            input bit msb_first);
    return msb_first ? {first_b, second_b} : {second_b, first_b};
  endfunction

  function automatic logic [7:0] word_byte(input logic [15:0] word,
                                           input bit msb_first,
                                           input bit second);
    return (msb_first ^ second) ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/uart_word_tx_serializer.sv
// Splits an acknowledged 16-bit word into two bytes for the UART transmitter,
// with zero-bubble hand-off to the next word.
module uart_word_tx_serializer
  import uart_word_pkg::*;
#(
  parameter bit MSB_FIRST = MSB_FIRST_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] tx_word,
  input  logic        tx_word_valid,
  output logic        tx_ack,
  output logic [7:0]  tx_byte,
  output logic        tx_byte_valid,
  input  logic        tx_byte_ready
);

  logic [1:0]  state;
  logic [15:0] word_q;

  assign tx_ack = enable & tx_word_valid &
                  ((state == TX_IDLE) | ((state == TX_SECOND) & tx_byte_ready));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= TX_IDLE;
      word_q <= 16'h0000;
    end else if (enable) begin
      if (tx_ack) begin
        word_q <= tx_word;
        state  <= TX_FIRST;
      end else begin
        case (state)
          TX_IDLE:   state <= TX_IDLE;
          TX_FIRST:  if (tx_byte_ready) state <= TX_SECOND;
          TX_SECOND: if (tx_byte_ready) state <= TX_IDLE;
          default:   state <= TX_IDLE;
        endcase
      end
    end
  end

  // Outputs decode purely from registered state, so tx_byte cannot move while valid.
  always_comb begin
    tx_byte = 8'h00;
    case (state)
      TX_FIRST:  tx_byte = word_byte(word_q, MSB_FIRST, 1'b0);
      TX_SECOND: tx_byte = word_byte(word_q, MSB_FIRST, 1'b1);
      default:   tx_byte = 8'h00;
    endcase
  end

  assign tx_byte_valid = (state == TX_FIRST) | (state == TX_SECOND);

endmodule

// File: rtl/uart_word_bridge.sv
// Byte <-> 16-bit word bridge between the UART core and the control unit.
// Define UART_WORD_BRIDGE_TIMEOUT_EN to enable the RX inter-byte timeout.
module uart_word_bridge
  import uart_word_pkg::*;
#(
  parameter bit MSB_FIRST      = MSB_FIRST_DEFAULT,
  parameter int TIMEOUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_byte_valid,
  input  logic        tx_byte_ready,
  output logic [15:0] rx_word,
  output logic        rx_word_valid,
  input  logic [15:0] tx_word,
  input  logic        tx_word_valid,
  output logic        tx_ack,
  input  logic        error_clear,
  output logic [1:0]  bridge_error
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES >= (1 << TIMEOUT_WIDTH)) begin : g_bad_timeout
    $error("uart_word_bridge: TIMEOUT_CYCLES out of range for TIMEOUT_WIDTH");
  end

  logic [0:0] rx_state;
  logic [7:0] first_q;
  logic       rx_timeout;
  logic [1:0] err_set;

`ifdef UART_WORD_BRIDGE_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_WIDTH-1:0] to_cnt;

  // A byte landing on the last count wins over the timeout.
  assign rx_timeout = enable & (rx_state == RX_SECOND) & ~rx_byte_valid & (to_cnt == TO_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (enable) begin
      if ((rx_state == RX_FIRST) & rx_byte_valid)
        to_cnt <= '0;
      else if ((rx_state == RX_SECOND) & ~rx_byte_valid & ~rx_timeout)
        to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign rx_timeout = 1'b0;
`endif

  always_comb begin
    err_set                 = 2'b00;
    err_set[ERR_RX_DROP]    = rx_byte_valid & ~enable;
    err_set[ERR_RX_TIMEOUT] = rx_timeout;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state      <= RX_FIRST;
      first_q       <= 8'h00;
      rx_word       <= 16'h0000;
      rx_word_valid <= 1'b0;
      bridge_error  <= 2'b00;
    end else begin
      rx_word_valid <= 1'b0;
      // New events are OR-ed in after the clear so they survive a coincident clear.
      bridge_error  <= (bridge_error & ~{2{error_clear}}) | err_set;
      if (enable) begin
        case (rx_state)
          RX_FIRST: begin
            if (rx_byte_valid) begin
              first_q  <= rx_byte;
              rx_state <= RX_SECOND;
            end
          end
          default: begin
            if (rx_byte_valid) begin
              rx_word       <= word_join(first_q, rx_byte, MSB_FIRST);
              rx_word_valid <= 1'b1;
              rx_state      <= RX_FIRST;
            end else if (rx_timeout) begin
              first_q  <= 8'h00;
              rx_state <= RX_FIRST;
            end
          end
        endcase
      end
    end
  end

  uart_word_tx_serializer #(
    .MSB_FIRST(MSB_FIRST)
  ) u_tx (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .tx_word       (tx_word),
    .tx_word_valid (tx_word_valid),
    .tx_ack        (tx_ack),
    .tx_byte       (tx_byte),
    .tx_byte_valid (tx_byte_valid),
    .tx_byte_ready (tx_byte_ready)
  );

endmodule

// File: tb/tb_uart_word_bridge.sv
// Directed bench for uart_word_bridge: an MSB-first and an LSB-first instance
// share one stimulus stream.
module tb_uart_word_bridge;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        tx_byte_ready;
  logic [15:0] tx_word;
  logic        tx_word_valid;
  logic        error_clear;

  logic [7:0]  m_tx_byte,  l_tx_byte;
  logic        m_tx_valid, l_tx_valid;
  logic [15:0] m_rx_word,  l_rx_word;
  logic        m_rx_valid, l_rx_valid;
  logic        m_tx_ack,   l_tx_ack;
  logic [1:0]  m_err,      l_err;

  int n_assert = 0;
  int n_fail   = 0;

  uart_word_bridge #(.MSB_FIRST(1'b1), .TIMEOUT_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .tx_byte(m_tx_byte), .tx_byte_valid(m_tx_valid), .tx_byte_ready(tx_byte_ready),
    .rx_word(m_rx_word), .rx_word_valid(m_rx_valid),
    .tx_word(tx_word), .tx_word_valid(tx_word_valid), .tx_ack(m_tx_ack),
    .error_clear(error_clear), .bridge_error(m_err)
  );

  uart_word_bridge #(.MSB_FIRST(1'b0), .TIMEOUT_WIDTH(16), .TIMEOUT_CYCLES(8)) dut_lsb (
    .clock(clock), .reset(reset), .enable(enable),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .tx_byte(l_tx_byte), .tx_byte_valid(l_tx_valid), .tx_byte_ready(tx_byte_ready),
    .rx_word(l_rx_word), .rx_word_valid(l_rx_valid),
    .tx_word(tx_word), .tx_word_valid(tx_word_valid), .tx_ack(l_tx_ack),
    .error_clear(error_clear), .bridge_error(l_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; rx_byte = 8'h00; rx_byte_valid = 1'b0;
    tx_byte_ready = 1'b0; tx_word = 16'h0000; tx_word_valid = 1'b0; error_clear = 1'b0;
    tick(); tick();
    chk("reset_rx_word", m_rx_word, 16'h0000);
    chk("reset_rx_valid", {15'd0, m_rx_valid}, 16'd0);
    chk("reset_tx_byte", {8'd0, m_tx_byte}, 16'd0);
    chk("reset_tx_valid", {15'd0, m_tx_valid}, 16'd0);
    chk("reset_err", {14'd0, m_err}, 16'd0);
    reset = 1'b0; enable = 1'b1;
    tick();

    // RX byte order: 0xA5 then 0x3C four cycles later
    rx_byte = 8'hA5; rx_byte_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0;
    chk("rx_no_early_valid", {15'd0, m_rx_valid}, 16'd0);
    tick(); tick(); tick();
    chk("rx_no_valid_gap", {15'd0, m_rx_valid}, 16'd0);
    rx_byte = 8'h3C; rx_byte_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0;
    chk("rx_msb_word", m_rx_word, 16'hA53C);
    chk("rx_msb_valid", {15'd0, m_rx_valid}, 16'd1);
    chk("rx_lsb_word", l_rx_word, 16'h3CA5);
    chk("rx_lsb_valid", {15'd0, l_rx_valid}, 16'd1);
    tick();
    chk("rx_valid_single", {15'd0, m_rx_valid}, 16'd0);
    chk("rx_word_hold", m_rx_word, 16'hA53C);

    // TX back-to-back with ready tied high
    tx_byte_ready = 1'b1; tx_word = 16'h1234; tx_word_valid = 1'b1;
    #1 chk("tx_ack_first", {15'd0, m_tx_ack}, 16'd1);
    tick();
    tx_word = 16'hBEEF;
    #1 chk("tx_ack_in_first", {15'd0, m_tx_ack}, 16'd0);
    chk("tx_b0", {8'd0, m_tx_byte}, 16'h0012);
    chk("tx_b0_valid", {15'd0, m_tx_valid}, 16'd1);
    chk("tx_lsb_b0", {8'd0, l_tx_byte}, 16'h0034);
    tick();
    chk("tx_b1", {8'd0, m_tx_byte}, 16'h0034);
    chk("tx_ack_second", {15'd0, m_tx_ack}, 16'd1);
    chk("tx_lsb_b1", {8'd0, l_tx_byte}, 16'h0012);
    tick();
    tx_word_valid = 1'b0;
    #1 chk("tx_b2", {8'd0, m_tx_byte}, 16'h00BE);
    chk("tx_b2_valid", {15'd0, m_tx_valid}, 16'd1);
    chk("tx_ack_none", {15'd0, m_tx_ack}, 16'd0);
    tick();
    chk("tx_b3", {8'd0, m_tx_byte}, 16'h00EF);
    tick();
    chk("tx_idle_valid", {15'd0, m_tx_valid}, 16'd0);
    tx_byte_ready = 1'b0;

    // TX stall on first byte of 0x00FF
    tx_word = 16'h00FF; tx_word_valid = 1'b1;
    #1 chk("stall_ack", {15'd0, m_tx_ack}, 16'd1);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("stall_byte", {8'd0, m_tx_byte}, 16'h0000);
      chk("stall_valid", {15'd0, m_tx_valid}, 16'd1);
      chk("stall_no_ack", {15'd0, m_tx_ack}, 16'd0);
      tick();
    end
    tx_byte_ready = 1'b1; tx_word_valid = 1'b0;
    tick();
    chk("stall_b1", {8'd0, m_tx_byte}, 16'h00FF);
    tick();
    chk("stall_done", {15'd0, m_tx_valid}, 16'd0);
    tx_byte_ready = 1'b0;

    // TX with enable low: byte held, ready ignored
    tx_word = 16'hCAFE; tx_word_valid = 1'b1;
    tick();
    tx_word_valid = 1'b0; enable = 1'b0; tx_byte_ready = 1'b1;
    tick(); tick();
    chk("tx_en_low_byte", {8'd0, m_tx_byte}, 16'h00CA);
    chk("tx_en_low_valid", {15'd0, m_tx_valid}, 16'd1);
    enable = 1'b1;
    tick();
    chk("tx_en_high_b1", {8'd0, m_tx_byte}, 16'h00FE);
    tick();
    tx_byte_ready = 1'b0;

    // RX byte dropped with enable low in the middle of a word
    rx_byte = 8'h5A; rx_byte_valid = 1'b1;
    tick();
    enable = 1'b0; rx_byte = 8'h77;
    tick();
    enable = 1'b1; rx_byte = 8'hC3;
    chk("drop_err", {14'd0, m_err}, 16'h0001);
    chk("drop_no_word", {15'd0, m_rx_valid}, 16'd0);
    tick();
    rx_byte_valid = 1'b0;
    chk("drop_state_kept", m_rx_word, 16'h5AC3);
    chk("drop_state_valid", {15'd0, m_rx_valid}, 16'd1);
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    chk("err_cleared", {14'd0, m_err}, 16'h0000);
    error_clear = 1'b1; enable = 1'b0; rx_byte_valid = 1'b1;
    tick();
    error_clear = 1'b0; enable = 1'b1; rx_byte_valid = 1'b0;
    chk("err_set_wins", {14'd0, m_err}, 16'h0001);
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    chk("err_cleared2", {14'd0, m_err}, 16'h0000);

`ifdef UART_WORD_BRIDGE_TIMEOUT_EN
    rx_byte = 8'h11; rx_byte_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("to_no_word", {15'd0, m_rx_valid}, 16'd0);
      tick();
    end
    chk("to_err", {14'd0, m_err}, 16'h0002);
    rx_byte = 8'h22; rx_byte_valid = 1'b1;
    tick();
    rx_byte = 8'h33;
    tick();
    rx_byte_valid = 1'b0;
    chk("to_recover_word", m_rx_word, 16'h2233);
    chk("to_recover_valid", {15'd0, m_rx_valid}, 16'd1);
    error_clear = 1'b1; rx_byte = 8'h44; rx_byte_valid = 1'b1;
    tick();
    error_clear = 1'b0; rx_byte_valid = 1'b0;
    repeat (7) tick();
    rx_byte = 8'h55; rx_byte_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0;
    chk("to_edge_word", m_rx_word, 16'h4455);
    chk("to_edge_valid", {15'd0, m_rx_valid}, 16'd1);
    chk("to_edge_err", {14'd0, m_err}, 16'h0000);
`else
    rx_byte = 8'h11; rx_byte_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0;
    repeat (10) tick();
    chk("noto_err", {14'd0, m_err}, 16'h0000);
    rx_byte = 8'h22; rx_byte_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0;
    chk("noto_word", m_rx_word, 16'h1122);
    chk("noto_valid", {15'd0, m_rx_valid}, 16'd1);
`endif

    // Async reset mid RX word and mid TX word
    enable = 1'b0; rx_byte_valid = 1'b1;
    tick();
    enable = 1'b1; rx_byte = 8'h99;
    tx_word = 16'hABCD; tx_word_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0; tx_word_valid = 1'b0;
    chk("pre_reset_tx_valid", {15'd0, m_tx_valid}, 16'd1);
    chk("pre_reset_err", {14'd0, m_err}, 16'h0001);
    #3 reset = 1'b1;
    #1 chk("areset_tx_valid", {15'd0, m_tx_valid}, 16'd0);
    chk("areset_tx_byte", {8'd0, m_tx_byte}, 16'd0);
    chk("areset_rx_word", m_rx_word, 16'h0000);
    chk("areset_err", {14'd0, m_err}, 16'h0000);
    tick();
    reset = 1'b0; tx_byte_ready = 1'b1;
    tick();
    rx_byte = 8'h66; rx_byte_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_reset_no_word", {15'd0, m_rx_valid}, 16'd0);
      chk("post_reset_no_tx", {15'd0, m_tx_valid}, 16'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
